axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Shares one AXI-Stream output among NUM_SRC AXI-Stream sources, e.g. several traffic generators feeding one NoC router/MVM ingress port.
- Round-robin arbitration at packet granularity: once granted, a source keeps the output until its tlast beat transfers.
- Output is fully registered (one pipeline stage) with full throughput. Source id is carried on m_axis_tid, and a transferred-packet counter is exposed.

Parameters:
- NUM_SRC, 4, number of source ports (2..16).
- DATA_WIDTH, 64, tdata width per port.
- ID_WIDTH, 2, width of m_axis_tid and grant index; must be >= clog2(NUM_SRC).
- CNT_WIDTH, 16, width of pkt_count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source data, source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tlast  in  NUM_SRC  per-source end-of-packet
- s_axis_tready  out  NUM_SRC  per-source ready (combinational)
- m_axis_tdata  out  DATA_WIDTH  registered output data
- m_axis_tvalid  out  1  registered output valid
- m_axis_tlast  out  1  registered output last
- m_axis_tid  out  ID_WIDTH  index of the source that produced the beat
- m_axis_tready  in  1  downstream ready
- grant_active  out  1  high while a packet is locked
- grant_idx  out  ID_WIDTH  currently locked source (valid when grant_active)
- pkt_count  out  CNT_WIDTH  number of packets (tlast beats) accepted into the output register

Behaviour:
- Reset (async, rst=1): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, grant_active=0, grant_idx=0, pkt_count=0, rr_ptr=0, FSM=IDLE. s_axis_tready is all-zero while rst=1.
- Load condition: load = !m_axis_tvalid || m_axis_tready. The output register accepts a new beat only when load=1.
- FSM IDLE:
  - sel = first i with s_axis_tvalid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - If any valid and load=1: assert s_axis_tready[sel] only and transfer the beat this cycle.
  - If that beat has tlast=1 (single-beat packet): stay in IDLE, rr_ptr <= sel+1 mod NUM_SRC.
  - Otherwise: go to LOCKED, grant_idx <= sel, grant_active <= 1.
  - If no valid, or load=0: no ready, no state change.
- FSM LOCKED:
  - s_axis_tready[grant_idx] = load; all other readys are 0. Other sources' valids are ignored.
  - On a transferred beat with tlast=1: go to IDLE, grant_active <= 0, rr_ptr <= grant_idx+1 mod NUM_SRC.
  - Source tvalid deasserting mid-packet (bubble) holds the lock. No timeout.
- Output register:
  - On a transfer: m_axis_tdata/tlast/tid <= selected source beat, m_axis_tvalid <= 1.
  - Else if m_axis_tready=1: m_axis_tvalid <= 0.
  - While tvalid=1 and tready=0, data/last/tid are held stable (AXIS rule).
- Timing: latency source->output is 1 cycle. Sustained 1 beat/cycle when m_axis_tready is held high. No combinational path from s_axis_tvalid to m_axis_tvalid. s_axis_tready depends combinationally on m_axis_tready and s_axis_tvalid; this is allowed.
- pkt_count: increments by 1 on every transferred tlast beat, wraps modulo 2^CNT_WIDTH.
- Fairness: with all sources continuously requesting, grants cycle 0,1,...,NUM_SRC-1,0. No source waits more than NUM_SRC-1 packets.
- rr_ptr wraps NUM_SRC-1 -> 0. For non-power-of-2 NUM_SRC, indices >= NUM_SRC are never selected.
- Reset mid-packet: the lock and the partial packet in the output register are dropped. After release, arbitration restarts from source 0.

Decomposition:
- Shared package noc_axis_pkg: AXIS field width constants (DATA_WIDTH default 64, MVM width 512/8) and the FSM state encoding IDLE=0/LOCKED=1.
- One natural sub-module: rr_pick (combinational, NUM_SRC-wide req vector + ptr -> one-hot/index + any_valid). Reusable by other NoC arbiters.
- FSM, output register and counter stay in the top module.

Test Plan:
- Reset then idle: all s_tvalid=0 for 10 cycles -> m_axis_tvalid=0, s_axis_tready=0, pkt_count=0, grant_active=0.
- Single source 2 streaming 4-beat packets (data 1..8), m_tready=1 -> m_axis_tdata 1..8 one per cycle starting 1 cycle after the first s_tvalid, tid=2, tlast on beats 4 and 8, pkt_count=2.
- All 4 sources streaming continuous 3-beat packets, m_tready=1 -> grant order 0,1,2,3,0,1; no interleaving within a packet; 12 beats in 12 cycles; pkt_count=4 after 4 packets.
- Backpressure: m_tready toggles 1,0,0,1,... during source 1's 4-beat packet -> m_axis fields stable while stalled, no beat lost or duplicated, s_axis_tready[1]=0 exactly when tvalid=1 and tready=0.
- Lock with bubble: source 0 sends beat 1, drops tvalid for 3 cycles while source 3 is valid -> source 3 not granted until source 0's tlast transfers; source 3 wins next.
- Async reset asserted mid-packet of source 1 (between clock edges) -> outputs clear immediately. After release with sources 1 and 0 valid, source 0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/noc_axis_pkg.sv
// Shared AXI-Stream constants and arbiter state encoding for the NoC ingress blocks.
package noc_axis_pkg;

  localparam int AXIS_DATA_WIDTH = 64;
  localparam int MVM_DATA_WIDTH  = 512;
  localparam int MVM_KEEP_WIDTH  = MVM_DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any_valid
);

  int cand;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_valid && (i == cand) && req[i]) begin
          any_valid = 1'b1;
          idx       = IDX_WIDTH'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = any_valid && (idx == IDX_WIDTH'(i));
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter with a registered output stage.
module axis_rr_arbiter
  import noc_axis_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int ID_WIDTH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  input  logic                          m_axis_tready,
  output logic                          grant_active,
  output logic [ID_WIDTH-1:0]           grant_idx,
  output logic [CNT_WIDTH-1:0]          pkt_count
);

  arb_state_t            state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic                  load;
  logic                  xfer;
  logic                  pick_any;
  logic [NUM_SRC-1:0]    pick_grant;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic [ID_WIDTH-1:0]   cur_idx;
  logic                  cur_valid;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [NUM_SRC-1:0]    lock_oh;
  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ   (NUM_SRC),
    .IDX_WIDTH (ID_WIDTH)
  ) u_pick (
    .req       (s_axis_tvalid),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign load    = !m_axis_tvalid || m_axis_tready;
  assign cur_idx = (state == ST_LOCKED) ? grant_idx : pick_idx;

  // While locked, only the owner's valid matters; other requests are ignored.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    lock_oh   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_idx == ID_WIDTH'(i)) begin
        cur_valid = s_axis_tvalid[i];
        cur_last  = s_axis_tlast[i];
        cur_data  = src_data[i];
      end
      lock_oh[i] = (grant_idx == ID_WIDTH'(i));
    end
    if (state == ST_IDLE) cur_valid = pick_any;
  end

  always_comb begin
    s_axis_tready = '0;
    if (!rst) begin
      if (state == ST_LOCKED) s_axis_tready = lock_oh & {NUM_SRC{load}};
      else                    s_axis_tready = pick_grant & {NUM_SRC{load}};
    end
  end

  assign xfer = load && cur_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant_active  <= 1'b0;
      grant_idx     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      pkt_count     <= '0;
    end else begin
      if (xfer) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= cur_data;
        m_axis_tlast  <= cur_last;
        m_axis_tid    <= cur_idx;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (xfer && cur_last) pkt_count <= pkt_count + 1'b1;

      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (cur_last) begin
              rr_ptr <= ID_WIDTH'(wrap_inc(int'(cur_idx), NUM_SRC));
            end else begin
              state        <= ST_LOCKED;
              grant_idx    <= cur_idx;
              grant_active <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (xfer && cur_last) begin
            state        <= ST_IDLE;
            grant_active <= 1'b0;
            rr_ptr       <= ID_WIDTH'(wrap_inc(int'(grant_idx), NUM_SRC));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: reset, streaming, fairness, backpressure, bubbles, async reset.
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tvalid = '0;
  logic [N-1:0]    s_axis_tlast  = '0;
  logic [N-1:0]    s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic [IW-1:0]   m_axis_tid;
  logic            m_axis_tready = 1'b1;
  logic            grant_active;
  logic [IW-1:0]   grant_idx;
  logic [CW-1:0]   pkt_count;
  logic [DW-1:0]   src_data [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign s_axis_tdata[gi*DW +: DW] = src_data[gi];
    end
  endgenerate

  axis_rr_arbiter #(
    .NUM_SRC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tready(m_axis_tready),
    .grant_active(grant_active), .grant_idx(grant_idx), .pkt_count(pkt_count)
  );

  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready)
      $display("xfer tid=%0d data=%0h last=%0b pkts=%0d", m_axis_tid, m_axis_tdata, m_axis_tlast, pkt_count);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_srcs();
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    for (int i = 0; i < N; i++) src_data[i] = '0;
  endtask

  task automatic do_reset();
    idle_srcs();
    m_axis_tready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int  b [N];
  int  exp_src;
  int  exp_b;
  int  consumed;
  logic [N-1:0] rdy;
  bit  tr_pat [10] = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 1};
  logic [7:0] exp_d [9] = '{8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3};

  initial begin
    idle_srcs();

    // Reset and idle
    step();
    s_axis_tvalid = 4'hF;
    #1;
    check_eq("rst_ready", 64'(s_axis_tready), 64'(0));
    check_eq("rst_mvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("rst_pkt", 64'(pkt_count), 64'(0));
    idle_srcs();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_eq("idle_mvalid", 64'(m_axis_tvalid), 64'(0));
      check_eq("idle_ready", 64'(s_axis_tready), 64'(0));
    end
    check_eq("idle_pkt", 64'(pkt_count), 64'(0));
    check_eq("idle_gact", 64'(grant_active), 64'(0));

    // Source 2 streams two 4-beat packets
    do_reset();
    for (int k = 0; k < 8; k++) begin
      src_data[2]   = 64'(k + 1);
      s_axis_tvalid = 4'b0100;
      s_axis_tlast  = (k % 4 == 3) ? 4'b0100 : 4'b0000;
      #1;
      check_eq("s2_ready", 64'(s_axis_tready), 64'(4'b0100));
      step();
      check_eq("s2_mvalid", 64'(m_axis_tvalid), 64'(1));
      check_eq("s2_data", m_axis_tdata, 64'(k + 1));
      check_eq("s2_tid", 64'(m_axis_tid), 64'(2));
      check_eq("s2_last", 64'(m_axis_tlast), 64'(k % 4 == 3));
      check_eq("s2_gact", 64'(grant_active), 64'(k % 4 != 3));
      if (grant_active) check_eq("s2_gidx", 64'(grant_idx), 64'(2));
    end
    idle_srcs();
    step();
    check_eq("s2_end_mvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("s2_pkt", 64'(pkt_count), 64'(2));

    // All sources stream 3-beat packets: grants rotate 0,1,2,3,0,1
    do_reset();
    for (int s = 0; s < N; s++) b[s] = 0;
    for (int c = 0; c < 18; c++) begin
      for (int s = 0; s < N; s++) begin
        src_data[s]     = 64'((s << 8) | b[s]);
        s_axis_tlast[s] = (b[s] % 3 == 2);
      end
      s_axis_tvalid = 4'hF;
      #1;
      exp_src = (c / 3) % 4;
      check_eq("rr_ready", 64'(s_axis_tready), 64'(1 << exp_src));
      rdy = s_axis_tready;
      step();
      for (int s = 0; s < N; s++) if (rdy[s]) b[s]++;
      exp_b = ((c / 3) / 4) * 3 + c % 3;
      check_eq("rr_mvalid", 64'(m_axis_tvalid), 64'(1));
      check_eq("rr_tid", 64'(m_axis_tid), 64'(exp_src));
      check_eq("rr_data", m_axis_tdata, 64'((exp_src << 8) | exp_b));
      check_eq("rr_last", 64'(m_axis_tlast), 64'(c % 3 == 2));
      if (c == 11) check_eq("rr_pkt4", 64'(pkt_count), 64'(4));
    end
    idle_srcs();
    step();
    check_eq("rr_pkt6", 64'(pkt_count), 64'(6));

    // Backpressure on source 1's 4-beat packet
    do_reset();
    b[1] = 0;
    consumed = 0;
    for (int c = 0; c < 10; c++) begin
      src_data[1]   = 64'(8'hA0 + b[1]);
      s_axis_tvalid = (b[1] < 4) ? 4'b0010 : 4'b0000;
      s_axis_tlast  = (b[1] == 3) ? 4'b0010 : 4'b0000;
      m_axis_tready = tr_pat[c];
      #1;
      check_eq("bp_ready", 64'(s_axis_tready), (c < 8 && tr_pat[c]) ? 64'(4'b0010) : 64'(0));
      if (m_axis_tvalid && m_axis_tready) begin
        check_eq("bp_consume", m_axis_tdata, 64'(8'hA0 + consumed));
        consumed++;
      end
      rdy = s_axis_tready;
      step();
      if (rdy[1]) b[1]++;
      check_eq("bp_mvalid", 64'(m_axis_tvalid), 64'(c < 9));
      if (c < 9) begin
        check_eq("bp_data", m_axis_tdata, 64'(exp_d[c]));
        check_eq("bp_last", 64'(m_axis_tlast), 64'(c >= 7));
      end
    end
    check_eq("bp_consumed", 64'(consumed), 64'(4));
    check_eq("bp_pkt", 64'(pkt_count), 64'(1));

    // Lock held through a bubble while source 3 waits
    do_reset();
    src_data[0] = 64'h10;
    src_data[3] = 64'h30;
    s_axis_tvalid = 4'b1001;
    s_axis_tlast  = 4'b1000;
    #1;
    check_eq("bub_ready0", 64'(s_axis_tready), 64'(4'b0001));
    step();
    check_eq("bub_tid0", 64'(m_axis_tid), 64'(0));
    check_eq("bub_data0", m_axis_tdata, 64'h10);
    s_axis_tvalid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("bub_hold_ready", 64'(s_axis_tready), 64'(4'b0001));
      step();
      check_eq("bub_hold_mvalid", 64'(m_axis_tvalid), 64'(0));
      check_eq("bub_hold_gact", 64'(grant_active), 64'(1));
      check_eq("bub_hold_gidx", 64'(grant_idx), 64'(0));
    end
    src_data[0]   = 64'h11;
    s_axis_tvalid = 4'b1001;
    s_axis_tlast  = 4'b1001;
    #1;
    check_eq("bub_ready_last", 64'(s_axis_tready), 64'(4'b0001));
    step();
    check_eq("bub_data_last", m_axis_tdata, 64'h11);
    check_eq("bub_last", 64'(m_axis_tlast), 64'(1));
    s_axis_tvalid = 4'b1000;
    #1;
    check_eq("bub_ready3", 64'(s_axis_tready), 64'(4'b1000));
    step();
    check_eq("bub_tid3", 64'(m_axis_tid), 64'(3));
    check_eq("bub_data3", m_axis_tdata, 64'h30);
    check_eq("bub_pkt", 64'(pkt_count), 64'(2));
    idle_srcs();
    step();

    // Asynchronous reset mid-packet
    do_reset();
    src_data[1]   = 64'h51;
    s_axis_tvalid = 4'b0010;
    step();
    check_eq("ar_pre_mvalid", 64'(m_axis_tvalid), 64'(1));
    check_eq("ar_pre_gact", 64'(grant_active), 64'(1));
    src_data[0]   = 64'h01;
    src_data[1]   = 64'h52;
    s_axis_tvalid = 4'b0011;
    s_axis_tlast  = 4'b0011;
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_mvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("ar_mdata", m_axis_tdata, 64'(0));
    check_eq("ar_gact", 64'(grant_active), 64'(0));
    check_eq("ar_ready", 64'(s_axis_tready), 64'(0));
    step();
    rst = 1'b0;
    #1;
    check_eq("ar_post_ready", 64'(s_axis_tready), 64'(4'b0001));
    step();
    check_eq("ar_post_tid0", 64'(m_axis_tid), 64'(0));
    check_eq("ar_post_data0", m_axis_tdata, 64'h01);
    s_axis_tvalid = 4'b0010;
    #1;
    check_eq("ar_post_ready1", 64'(s_axis_tready), 64'(4'b0010));
    step();
    check_eq("ar_post_tid1", 64'(m_axis_tid), 64'(1));
    check_eq("ar_post_data1", m_axis_tdata, 64'h52);
    idle_srcs();
    step();
    check_eq("ar_post_mvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("ar_post_pkt", 64'(pkt_count), 64'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
